axi_dma_cmd_arbiter: RTL and testbench

//  Shares the single DMA command port of axi_dma_controller among REQ_COUNT requesters.

---
 rtl/axi_dma_cmd_arbiter.sv | 164 ++++++++++++++++
 tb/tb_axi_dma_cmd_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_dma_cmd_arbiter.sv
// axi_dma_cmd_arbiter
// Round-robin arbiter sharing the DMA core command port among REQ_COUNT
// requesters. The winning command is captured in a one-entry registered slot,
// tagged with the index of the requester that issued it. Zero-length commands
// are accepted and dropped, reported by a one-cycle zero_len_drop pulse.

module axi_dma_cmd_arbiter #(
  parameter  int ADDR_WD   = 32,
  parameter  int LEN_WD    = 32,
  parameter  int REQ_COUNT = 4,
  localparam int ID_WD     = $clog2(REQ_COUNT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_COUNT-1:0]         req_mask,
  input  logic [REQ_COUNT-1:0]         req_valid,
  output logic [REQ_COUNT-1:0]         req_ready,
  input  logic [REQ_COUNT*ADDR_WD-1:0] req_src_addr,
  input  logic [REQ_COUNT*ADDR_WD-1:0] req_dst_addr,
  input  logic [REQ_COUNT*2-1:0]       req_burst,
  input  logic [REQ_COUNT*LEN_WD-1:0]  req_len,
  input  logic [REQ_COUNT*3-1:0]       req_size,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [ADDR_WD-1:0]           cmd_src_addr,
  output logic [ADDR_WD-1:0]           cmd_dst_addr,
  output logic [1:0]                   cmd_burst,
  output logic [LEN_WD-1:0]            cmd_len,
  output logic [2:0]                   cmd_size,
  output logic [ID_WD-1:0]             cmd_id,
  output logic                         zero_len_drop
);

  // Per-requester views of the packed payload buses.
  logic [ADDR_WD-1:0] src_arr   [REQ_COUNT];
  logic [ADDR_WD-1:0] dst_arr   [REQ_COUNT];
  logic [1:0]         burst_arr [REQ_COUNT];
  logic [LEN_WD-1:0]  len_arr   [REQ_COUNT];
  logic [2:0]         size_arr  [REQ_COUNT];

  // Slot and arbitration state.
  logic               cmd_valid_q,  cmd_valid_d;
  logic [ADDR_WD-1:0] src_q,        src_d;
  logic [ADDR_WD-1:0] dst_q,        dst_d;
  logic [1:0]         burst_q,      burst_d;
  logic [LEN_WD-1:0]  len_q,        len_d;
  logic [2:0]         size_q,       size_d;
  logic [ID_WD-1:0]   id_q,         id_d;
  logic [ID_WD-1:0]   last_grant_q, last_grant_d;
  logic               drop_q,       drop_d;

  logic [REQ_COUNT-1:0] eligible;
  logic                 load_en;
  logic                 grant_found;
  logic [ID_WD-1:0]     grant_idx;
  logic                 accept;

  // Split the packed request buses into per-requester fields.
  always_comb begin
    for (int i = 0; i < REQ_COUNT; i++) begin
      src_arr[i]   = req_src_addr[i*ADDR_WD +: ADDR_WD];
      dst_arr[i]   = req_dst_addr[i*ADDR_WD +: ADDR_WD];
      burst_arr[i] = req_burst[i*2 +: 2];
      len_arr[i]   = req_len[i*LEN_WD +: LEN_WD];
      size_arr[i]  = req_size[i*3 +: 3];
    end
  end

  assign eligible = req_valid & req_mask;
  // The slot can take a new command when empty or being drained this cycle.
  assign load_en  = !cmd_valid_q || cmd_ready;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int cand;
    // NOTE: every variable driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= REQ_COUNT; k++) begin
      cand = (int'(last_grant_q) + k) % REQ_COUNT;
      if (!grant_found && eligible[cand[ID_WD-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_WD-1:0];
      end
    end
  end

  // No handshake while reset is held: the slot could not capture it.
  assign accept = load_en && grant_found && !rst;

  // Next-state for the slot, the grant pointer and the ready vector.
  always_comb begin
    cmd_valid_d  = cmd_valid_q;
    src_d        = src_q;
    dst_d        = dst_q;
    burst_d      = burst_q;
    len_d        = len_q;
    size_d       = size_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    drop_d       = 1'b0;
    req_ready    = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
      last_grant_d         = grant_idx;
      if (len_arr[grant_idx] != '0) begin
        cmd_valid_d = 1'b1;
        src_d       = src_arr[grant_idx];
        dst_d       = dst_arr[grant_idx];
        burst_d     = burst_arr[grant_idx];
        len_d       = len_arr[grant_idx];
        size_d      = size_arr[grant_idx];
        id_d        = grant_idx;
      end else begin
        // Zero-length command is consumed without occupying the slot.
        cmd_valid_d = 1'b0;
        drop_d      = 1'b1;
      end
    end else if (load_en) begin
      cmd_valid_d = 1'b0;
    end
  end

  // State registers; reset empties the slot without any core handshake.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the reset branch clears every register, including the payload,
    // so the outputs read as zero out of reset rather than X.
    if (rst) begin
      cmd_valid_q  <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      burst_q      <= '0;
      len_q        <= '0;
      size_q       <= '0;
      id_q         <= '0;
      last_grant_q <= ID_WD'(REQ_COUNT - 1);
      drop_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values regardless of statement order.
      cmd_valid_q  <= cmd_valid_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      burst_q      <= burst_d;
      len_q        <= len_d;
      size_q       <= size_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      drop_q       <= drop_d;
    end
  end

  assign cmd_valid     = cmd_valid_q;
  assign cmd_src_addr  = src_q;
  assign cmd_dst_addr  = dst_q;
  assign cmd_burst     = burst_q;
  assign cmd_len       = len_q;
  assign cmd_size      = size_q;
  assign cmd_id        = id_q;
  assign zero_len_drop = drop_q;

endmodule

// File: tb/tb_axi_dma_cmd_arbiter.sv
// Directed testbench for axi_dma_cmd_arbiter (4 requesters, 32-bit fields).
// Inputs change 1 ns after the rising edge; outputs are checked before the
// next rising edge.

module tb_axi_dma_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_mask;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [127:0] req_src_addr;
  logic [127:0] req_dst_addr;
  logic [7:0]  req_burst;
  logic [127:0] req_len;
  logic [11:0] req_size;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_src_addr;
  logic [31:0] cmd_dst_addr;
  logic [1:0]  cmd_burst;
  logic [31:0] cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_id;
  logic        zero_len_drop;

  logic [31:0] src_a   [4];
  logic [31:0] dst_a   [4];
  logic [31:0] len_a   [4];
  logic [1:0]  burst_a [4];
  logic [2:0]  size_a  [4];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign req_src_addr[g*32 +: 32] = src_a[g];
    assign req_dst_addr[g*32 +: 32] = dst_a[g];
    assign req_len[g*32 +: 32]      = len_a[g];
    assign req_burst[g*2 +: 2]      = burst_a[g];
    assign req_size[g*3 +: 3]       = size_a[g];
  end

  axi_dma_cmd_arbiter #(.ADDR_WD(32), .LEN_WD(32), .REQ_COUNT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_mask      (req_mask),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_src_addr  (req_src_addr),
    .req_dst_addr  (req_dst_addr),
    .req_burst     (req_burst),
    .req_len       (req_len),
    .req_size      (req_size),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_src_addr  (cmd_src_addr),
    .cmd_dst_addr  (cmd_dst_addr),
    .cmd_burst     (cmd_burst),
    .cmd_len       (cmd_len),
    .cmd_size      (cmd_size),
    .cmd_id        (cmd_id),
    .zero_len_drop (zero_len_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_default_payloads();
    for (int i = 0; i < 4; i++) begin
      src_a[i]   = 32'hA000 + 32'(i);
      dst_a[i]   = 32'hB000 + 32'(i);
      len_a[i]   = 32'h100 + 32'(i);
      burst_a[i] = 2'b01;
      size_a[i]  = 3'd3;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'b0000;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_mask  = 4'b1111;
    req_valid = 4'b0000;
    cmd_ready = 1'b0;
    load_default_payloads();
    step();
    step();
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid);
    end
    n_checks++;
    if (zero_len_drop !== 1'b0) begin
      n_fail++; $display("FAIL reset_zero_len_drop: got %b expected 0", zero_len_drop);
    end
    n_checks++;
    if ({cmd_src_addr, cmd_dst_addr, cmd_len, cmd_burst, cmd_size, cmd_id} !== 103'd0) begin
      n_fail++;
      $display("FAIL reset_payload: got src=%h dst=%h len=%h burst=%h size=%h id=%h expected all 0",
               cmd_src_addr, cmd_dst_addr, cmd_len, cmd_burst, cmd_size, cmd_id);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_req_ready_idle: got %b expected 0000", req_ready);
    end
  endtask

  task automatic test_single();
    src_a[1]   = 32'h1000;
    dst_a[1]   = 32'h2000;
    len_a[1]   = 32'd64;
    size_a[1]  = 3'd2;
    burst_a[1] = 2'b01;
    cmd_ready  = 1'b1;
    req_valid  = 4'b0010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL single_req_ready: got %b expected 0010", req_ready);
    end
    step();
    req_valid = 4'b0000;
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_id !== 2'd1) begin
      n_fail++; $display("FAIL single_valid_id: got valid=%b id=%0d expected valid=1 id=1", cmd_valid, cmd_id);
    end
    n_checks++;
    if (cmd_src_addr !== 32'h1000 || cmd_dst_addr !== 32'h2000 || cmd_len !== 32'd64 ||
        cmd_size !== 3'd2 || cmd_burst !== 2'b01) begin
      n_fail++;
      $display("FAIL single_payload: got src=%h dst=%h len=%0d size=%0d burst=%0d expected 1000 2000 64 2 1",
               cmd_src_addr, cmd_dst_addr, cmd_len, cmd_size, cmd_burst);
    end
    step();
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: got cmd_valid=%b expected 0", cmd_valid);
    end
    load_default_payloads();
  endtask

  task automatic test_back_to_back();
    do_reset();
    cmd_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 6; k++) begin
      int exp_g;
      exp_g = k % 4;
      n_checks++;
      if (req_ready !== 4'(1 << exp_g)) begin
        n_fail++; $display("FAIL rr_req_ready[%0d]: got %b expected %b", k, req_ready, 4'(1 << exp_g));
      end
      step();
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_id !== 2'(exp_g) || cmd_len !== 32'h100 + 32'(exp_g)) begin
        n_fail++;
        $display("FAIL rr_cmd[%0d]: got valid=%b id=%0d len=%h expected valid=1 id=%0d len=%h",
                 k, cmd_valid, cmd_id, cmd_len, exp_g, 32'h100 + 32'(exp_g));
      end
    end
  endtask

  task automatic test_stall();
    cmd_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL stall_req_ready[%0d]: got %b expected 0000", k, req_ready);
      end
      step();
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_id !== 2'd1 || cmd_src_addr !== 32'hA001 || cmd_len !== 32'h101) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got valid=%b id=%0d src=%h len=%h expected 1 1 a001 101",
                 k, cmd_valid, cmd_id, cmd_src_addr, cmd_len);
      end
    end
    cmd_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL stall_resume_ready: got %b expected 0100", req_ready);
    end
    step();
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_id !== 2'd2 || cmd_src_addr !== 32'hA002) begin
      n_fail++; $display("FAIL stall_resume_cmd: got valid=%b id=%0d src=%h expected 1 2 a002",
                         cmd_valid, cmd_id, cmd_src_addr);
    end
    req_valid = 4'b0000;
    step();
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_drain: got cmd_valid=%b expected 0", cmd_valid);
    end
  endtask

  task automatic test_zero_len();
    len_a[2]  = 32'd0;
    req_valid = 4'b0100;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL zlen_req_ready: got %b expected 0100", req_ready);
    end
    step();
    n_checks++;
    if (zero_len_drop !== 1'b1 || cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL zlen_drop: got drop=%b valid=%b expected drop=1 valid=0",
                         zero_len_drop, cmd_valid);
    end
    len_a[2]  = 32'h102;
    req_valid = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL zlen_next_grant: got %b expected 1000", req_ready);
    end
    step();
    n_checks++;
    if (zero_len_drop !== 1'b0 || cmd_valid !== 1'b1 || cmd_id !== 2'd3) begin
      n_fail++; $display("FAIL zlen_after: got drop=%b valid=%b id=%0d expected 0 1 3",
                         zero_len_drop, cmd_valid, cmd_id);
    end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_mask();
    int seq [6] = '{0, 2, 3, 0, 2, 3};
    req_mask  = 4'b1101;
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (req_ready !== 4'(1 << seq[k])) begin
        n_fail++; $display("FAIL mask_req_ready[%0d]: got %b expected %b", k, req_ready, 4'(1 << seq[k]));
      end
      step();
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_id !== 2'(seq[k])) begin
        n_fail++; $display("FAIL mask_cmd_id[%0d]: got valid=%b id=%0d expected 1 %0d",
                           k, cmd_valid, cmd_id, seq[k]);
      end
    end
    req_valid = 4'b0000;
    req_mask  = 4'b1111;
    step();
  endtask

  task automatic test_reset_mid();
    cmd_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    step();
    req_valid = 4'b0000;
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_id !== 2'd1) begin
      n_fail++; $display("FAIL rstmid_loaded: got valid=%b id=%0d expected 1 1", cmd_valid, cmd_id);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (cmd_valid !== 1'b0 || cmd_src_addr !== 32'h0 || cmd_id !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_async_clear: got valid=%b src=%h id=%0d expected 0 0 0",
                         cmd_valid, cmd_src_addr, cmd_id);
    end
    step();
    step();
    req_valid = 4'b1111;
    cmd_ready = 1'b1;
    rst       = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid_first_grant: got %b expected 0001", req_ready);
    end
    step();
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_id !== 2'd0 || cmd_src_addr !== 32'hA000) begin
      n_fail++; $display("FAIL rstmid_first_cmd: got valid=%b id=%0d src=%h expected 1 0 a000",
                         cmd_valid, cmd_id, cmd_src_addr);
    end
    req_valid = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_zero_len();
    test_mask();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
